rca64_issue_capture: RTL and testbench

RCA64_ISSUE_CAPTURE -- requirements
Module: rca64_issue_capture

---
 rtl/rca64_issue_capture.sv | 139 +++++++++++++
 tb/tb_rca64_issue_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca64_issue_capture.sv
// Operand register and result capture around an external 64-bit ripple-carry adder.
// Operands are held stable for SETTLE_CYCLES edges before the adder outputs are sampled.
`timescale 1ns/1ps

module rca64_issue_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_cin,
    output logic [63:0] add_a,
    output logic [63:0] add_b,
    output logic        add_cin,
    input  logic [63:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_cout,
    output logic        out_ovf,
    output logic [15:0] op_count
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] add_a_q, add_a_d;
    logic [63:0] add_b_q, add_b_d;
    logic        add_cin_q, add_cin_d;
    logic [63:0] out_sum_q, out_sum_d;
    logic        out_cout_q, out_cout_d;
    logic        out_ovf_q, out_ovf_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] op_count_q, op_count_d;
    logic        in_ready_c;
    logic        ovf_c;

    assign ovf_c = (add_a_q[63] == add_b_q[63]) && (add_sum[63] != add_a_q[63]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;
        in_ready_c  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
            end
            SETTLE: begin
                if (cnt_q > 8'd1) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    cnt_d       = '0;
                    out_sum_d   = add_sum;
                    out_cout_d  = add_cout;
                    out_ovf_d   = ovf_c;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                in_ready_c = out_ready;
                if (out_ready) begin
                    op_count_d  = op_count_q + 16'd1;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accept overrides the HOLD->IDLE release so both happen on one edge.
        if (in_valid && in_ready_c) begin
            add_a_d   = in_a;
            add_b_d   = in_b;
            add_cin_d = in_cin;
            cnt_d     = SETTLE_LOAD;
            state_d   = SETTLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_rca64_issue_capture.sv
// Scoreboard bench: two instances (SETTLE_CYCLES=4 and 1) with a behavioural adder each;
// the driver queues hand-computed results, a negedge monitor checks them as they appear.
`timescale 1ns/1ps

module tb_rca64_issue_capture;

    typedef struct {
        int          inst;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [63:0] in_a      [2];
    logic [63:0] in_b      [2];
    logic        in_cin    [2];
    logic [63:0] add_a     [2];
    logic [63:0] add_b     [2];
    logic        add_cin   [2];
    logic [63:0] add_sum   [2];
    logic        add_cout  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_sum   [2];
    logic        out_cout  [2];
    logic        out_ovf   [2];
    logic [15:0] op_count  [2];

    exp_t sbq[$];
    exp_t mon_e;
    logic prev_v [2];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign {add_cout[0], add_sum[0]} = 65'(add_a[0]) + 65'(add_b[0]) + 65'(add_cin[0]);
    assign {add_cout[1], add_sum[1]} = 65'(add_a[1]) + 65'(add_b[1]) + 65'(add_cin[1]);

    rca64_issue_capture #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
        .add_sum(add_sum[0]), .add_cout(add_cout[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_cout(out_cout[0]), .out_ovf(out_ovf[0]),
        .op_count(op_count[0])
    );

    rca64_issue_capture #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
        .add_sum(add_sum[1]), .add_cout(add_cout[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_cout(out_cout[1]), .out_ovf(out_ovf[1]),
        .op_count(op_count[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Drive operands from a negedge and hold in_valid until an accept edge.
    task automatic issue(input int k, input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic [63:0] es, input logic ec, input logic eo, output int acc);
        logic r;
        exp_t e;
        acc = -1;
        @(negedge clk);
        in_a[k] = a;
        in_b[k] = b;
        in_cin[k] = cin;
        in_valid[k] = 1'b1;
        for (int n = 0; n < 100; n++) begin
            #1 r = in_ready[k];
            @(posedge clk);
            if (r) begin
                #1;
                acc = cyc;
                e.inst = k; e.sum = es; e.cout = ec; e.ovf = eo;
                e.acc = acc; e.lat = (k == 0) ? 4 : 1;
                sbq.push_back(e);
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) timeout_fail("accept");
    endtask

    task automatic wait_done(input int k);
        int n;
        @(negedge clk);
        in_valid[k] = 1'b0;
        n = 0;
        #2;
        while ((sbq.size() != 0 || out_valid[k]) && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 60) timeout_fail("result_wait");
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n === 1'b1 && out_valid[k] && !prev_v[k]) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result inst=%0d: got sum %h expected no result", k, out_sum[k]);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result_inst", 64'(k), 64'(mon_e.inst));
                    chk("out_sum", out_sum[k], mon_e.sum);
                    chk("out_cout", 64'(out_cout[k]), 64'(mon_e.cout));
                    chk("out_ovf", 64'(out_ovf[k]), 64'(mon_e.ovf));
                    chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
            prev_v[k] <= out_valid[k];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int accs [4];
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; in_cin[k] = 1'b0;
            out_ready[k] = 1'b1; prev_v[k] = 1'b0;
        end
        #1;
        chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_add_a", add_a[0], 64'd0);
        chk("rst_out_sum", out_sum[0], 64'd0);
        chk("rst_op_count", 64'(op_count[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_add_a", add_a[0], 64'd0);
        chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);

        issue(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, acc);
        wait_done(0);
        chk("op_count_1", 64'(op_count[0]), 64'd1);

        issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, acc);
        wait_done(0);
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, acc);
        wait_done(0);
        issue(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1, acc);
        wait_done(0);
        chk("op_count_4", 64'(op_count[0]), 64'd4);

        // Backpressure: result held while in_valid stays high, then release+accept together.
        @(negedge clk);
        out_ready[0] = 1'b0;
        issue(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 64'h2222_2222_2222_2212, 1'b0, 1'b0, acc);
        for (int n = 0; n < 20 && !out_valid[0]; n++) @(negedge clk);
        chk("hold_valid_seen", 64'(out_valid[0]), 64'd1);
        in_a[0] = 64'd5;
        in_b[0] = 64'd3;
        in_cin[0] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid[0]), 64'd1);
            chk("hold_out_sum", out_sum[0], 64'h2222_2222_2222_2212);
            chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
            chk("hold_add_a", add_a[0], 64'h1234_5678_9ABC_DEF0);
            chk("hold_op_count", 64'(op_count[0]), 64'd4);
        end
        out_ready[0] = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        mon_e.inst = 0; mon_e.sum = 64'd8; mon_e.cout = 1'b0; mon_e.ovf = 1'b0;
        mon_e.acc = cyc; mon_e.lat = 4;
        sbq.push_back(mon_e);
        chk("simul_add_a", add_a[0], 64'd5);
        chk("simul_out_valid", 64'(out_valid[0]), 64'd0);
        chk("simul_in_ready_settle", 64'(in_ready[0]), 64'd0);
        chk("simul_op_count", 64'(op_count[0]), 64'd5);
        wait_done(0);
        chk("op_count_6", 64'(op_count[0]), 64'd6);
        chk("held_after_release", out_sum[0], 64'd8);

        // Asynchronous reset in the middle of SETTLE aborts the operation.
        issue(0, 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, acc);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid[0] = 1'b0;
        void'(sbq.pop_back());
        #1;
        chk("abort_add_a", add_a[0], 64'd0);
        chk("abort_out_sum", out_sum[0], 64'd0);
        chk("abort_op_count", 64'(op_count[0]), 64'd0);
        chk("abort_in_ready", 64'(in_ready[0]), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("abort_no_valid", 64'(out_valid[0]), 64'd0);
        end
        issue(0, 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 1'b0, acc);
        wait_done(0);
        chk("after_abort_op_count", 64'(op_count[0]), 64'd1);

        // SETTLE_CYCLES=1, back-to-back operands.
        issue(1, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, accs[0]);
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, accs[1]);
        issue(1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, accs[2]);
        issue(1, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0, accs[3]);
        wait_done(1);
        for (int i = 0; i < 3; i++) chk("b2b_interval", 64'(accs[i+1] - accs[i]), 64'd2);
        chk("b2b_op_count", 64'(op_count[1]), 64'd4);

        @(negedge clk);
        force u_dut1.op_count_q = 16'hFFFF;
        #1;
        release u_dut1.op_count_q;
        #1;
        chk("preload_op_count", 64'(op_count[1]), 64'hFFFF);
        issue(1, 64'd2, 64'd3, 1'b0, 64'd5, 1'b0, 1'b0, acc);
        wait_done(1);
        chk("wrap_op_count", 64'(op_count[1]), 64'd0);

        if (sbq.size() != 0) timeout_fail("scoreboard_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
